dly_tap_cal_ctrl: RTL and testbench

Calibration controller for a tapped chain of 9-track delay cells. Sweeps the chain's tap-select code upward from zero and majority-votes a phase-detector flag at each tap. It locks on the first tap whose delayed strobe no longer arrives early. Sits beside the delay chain and its tap mux; drives the mux select and reports lock or fail to the system controller.

---
 rtl/dly_cal_pkg.sv | 21 ++
 rtl/dly_vote_acc.sv | 48 ++++
 rtl/dly_tap_cal_ctrl.sv | 130 +++++++++++++
 tb/tb_dly_tap_cal_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dly_cal_pkg.sv
// Shared definitions for the delay-tap calibration controller: FSM states and
// helpers that derive sample count and settle-counter width from parameters.
package dly_cal_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        EVAL   = 3'd3,
        FIN    = 3'd4
    } cal_state_e;

    function automatic int nsamp(input int avg_w);
        return 1 << avg_w;
    endfunction

    function automatic int settle_cnt_w(input int settle_cyc);
        return $clog2(settle_cyc + 1);
    endfunction

endpackage

// File: rtl/dly_vote_acc.sv
// Per-tap vote accumulator: counts NSAMP samples of EARLY and reports whether
// a strict majority of them were early (a tie counts as late).
module dly_vote_acc
    import dly_cal_pkg::*;
#(
    parameter int AVG_W = 3
) (
    input  logic CLK,
    input  logic RN,
    input  logic clr,
    input  logic en,
    input  logic EARLY,
    output logic last_sample,
    output logic early_maj
);

    localparam int NSAMP = nsamp(AVG_W);

    logic [AVG_W-1:0] samp_q, samp_d;
    logic [AVG_W:0]   vote_q, vote_d;

    always_comb begin
        samp_d = samp_q;
        vote_d = vote_q;
        if (clr) begin
            samp_d = '0;
            vote_d = '0;
        end else if (en) begin
            samp_d = samp_q + AVG_W'(1);
            vote_d = vote_q + (AVG_W + 1)'(EARLY);
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            samp_q <= '0;
            vote_q <= '0;
        end else begin
            samp_q <= samp_d;
            vote_q <= vote_d;
        end
    end

    // The vote register is one bit wider than the sample count, so NSAMP votes fit.
    assign last_sample = (samp_q == AVG_W'(NSAMP - 1));
    assign early_maj   = (vote_q > (AVG_W + 1)'(NSAMP / 2));

endmodule

// File: rtl/dly_tap_cal_ctrl.sv
// Delay-chain tap calibration: sweeps TAP upward from zero and locks on the
// first tap whose majority-voted phase-detector flag reads late.
module dly_tap_cal_ctrl
    import dly_cal_pkg::*;
#(
    parameter int NTAPS      = 16,
    parameter int TAP_W      = 4,
    parameter int SETTLE_CYC = 4,
    parameter int AVG_W      = 3
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             EARLY,
    output logic [TAP_W-1:0] TAP,
    output logic             BUSY,
    output logic             DONE,
    output logic             LOCK,
    output logic             FAIL
);

    localparam int               SCW         = settle_cnt_w(SETTLE_CYC);
    localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(NTAPS - 1);
    localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE_CYC - 1);

    cal_state_e       state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [SCW-1:0]   settle_q, settle_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lock_q, lock_d;
    logic             fail_q, fail_d;

    logic vote_clr, vote_en, last_sample, early_maj;

    // Counters are cleared throughout settling so sampling always starts fresh.
    assign vote_clr = (state_q == SETTLE);
    assign vote_en  = (state_q == SAMPLE);

    dly_vote_acc #(
        .AVG_W (AVG_W)
    ) u_vote (
        .CLK         (CLK),
        .RN          (RN),
        .clr         (vote_clr),
        .en          (vote_en),
        .EARLY       (EARLY),
        .last_sample (last_sample),
        .early_maj   (early_maj)
    );

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = done_q;
        lock_d   = lock_q;
        fail_d   = fail_q;
        unique case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    state_d  = SETTLE;
                    tap_d    = '0;
                    settle_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    lock_d   = 1'b0;
                    fail_d   = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + SCW'(1);
                end
            end
            SAMPLE: begin
                if (last_sample) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                // TAP only moves here, so the mux select is stable while sampling.
                if (early_maj && (tap_q != TAP_MAX)) begin
                    state_d  = SETTLE;
                    tap_d    = tap_q + TAP_W'(1);
                    settle_d = '0;
                end else begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    lock_d  = !early_maj && (tap_q != '0);
                    fail_d  = early_maj || (tap_q == '0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lock_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lock_q   <= lock_d;
            fail_q   <= fail_d;
        end
    end

    assign TAP  = tap_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign LOCK = lock_q;
    assign FAIL = fail_q;

endmodule

// File: tb/tb_dly_tap_cal_ctrl.sv
// Self-checking bench for dly_tap_cal_ctrl: directed vector table, randomized
// EARLY sequences scored by a vote-counting reference model, and corner cases.
module tb_dly_tap_cal_ctrl;

    localparam int NTAPS   = 16;
    localparam int SETTLE  = 4;
    localparam int NSAMP   = 8;
    localparam int PER_TAP = SETTLE + NSAMP + 1;
    localparam int MAXCYC  = NTAPS * PER_TAP;

    logic       clk = 1'b0;
    logic       rn = 1'b1;
    logic       start = 1'b0;
    logic       early = 1'b0;
    logic [3:0] tap;
    logic       busy, done, lock, fail;
    logic [7:0] stat;

    int nChecks = 0;
    int nFails  = 0;

    // seq[j] is the EARLY level sampled by the j-th edge after the START edge.
    bit seq [0:MAXCYC];

    typedef struct {
        string name;
        int    mode;
        int    param;
        int    expTap;
        bit    expLock;
        bit    expFail;
        int    expEnd;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    dly_tap_cal_ctrl #(
        .NTAPS      (NTAPS),
        .TAP_W      (4),
        .SETTLE_CYC (SETTLE),
        .AVG_W      (3)
    ) dut (
        .CLK   (clk),
        .RN    (rn),
        .START (start),
        .EARLY (early),
        .TAP   (tap),
        .BUSY  (busy),
        .DONE  (done),
        .LOCK  (lock),
        .FAIL  (fail)
    );

    assign stat = {tap, busy, done, lock, fail};

    function automatic logic [7:0] packStat(input int t, input bit b, input bit d,
                                            input bit l, input bit f);
        return {t[3:0], b, d, l, f};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got tap=%0d busy=%b done=%b lock=%b fail=%b, expected tap=%0d busy=%b done=%b lock=%b fail=%b",
                     name, act[7:4], act[3], act[2], act[1], act[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit e);
        @(negedge clk);
        start = s;
        early = e;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rn = 1'b0;
        #1;
        checkOutput("resetAssert", stat, packStat(0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        start = 1'b0;
        rn = 1'b1;
    endtask

    task automatic fillThreshold(input int p);
        seq[0] = 1'b0;
        for (int j = 1; j <= MAXCYC; j++) seq[j] = ((j - 1) / PER_TAP) < p;
    endtask

    // Taps 0,1 fully early; tap 2 early on its first cnt samples (settle cycles high).
    task automatic fillVotes(input int cnt);
        seq[0] = 1'b0;
        for (int j = 1; j <= MAXCYC; j++) begin
            int t;
            int s;
            t = (j - 1) / PER_TAP;
            s = (j - 1) % PER_TAP - SETTLE;
            if (t < 2)       seq[j] = 1'b1;
            else if (t == 2) seq[j] = (s < 0) ? 1'b1 : (s < cnt);
            else             seq[j] = 1'b0;
        end
    endtask

    task automatic fillRandom(input int lockAt);
        seq[0] = 1'(($urandom_range(0, 1)));
        for (int j = 1; j <= MAXCYC; j++) begin
            int pct;
            pct = (((j - 1) / PER_TAP) < lockAt) ? 80 : 20;
            seq[j] = ($urandom_range(0, 99) < pct);
        end
    endtask

    // Reference: count the early samples of each tap's window and apply the sweep rules.
    task automatic model(output int eTap, output bit eLock, output bit eFail, output int eEnd);
        eTap = NTAPS - 1; eLock = 1'b0; eFail = 1'b1; eEnd = MAXCYC;
        for (int t = 0; t < NTAPS; t++) begin
            int votes;
            votes = 0;
            for (int i = 0; i < NSAMP; i++) votes += int'(seq[PER_TAP * t + SETTLE + 1 + i]);
            if (votes * 2 <= NSAMP) begin
                eTap  = t;
                eLock = (t > 0);
                eFail = (t == 0);
                eEnd  = PER_TAP * (t + 1);
                return;
            end
        end
    endtask

    task automatic runCal(input string name, input int eTap, input bit eLock, input bit eFail,
                          input int eEnd, input int pulseAt, input bit holdStart);
        applyStimulus(1'b1, seq[0]);
        checkOutput({name, " startEdge"}, stat, packStat(0, 1, 0, 0, 0));
        for (int j = 1; j <= eEnd; j++) begin
            int tExp;
            applyStimulus((j == pulseAt) || (holdStart && (j == eEnd)), seq[j]);
            if (j < eEnd) begin
                tExp = j / PER_TAP;
                if (tExp > eTap) tExp = eTap;
                checkOutput($sformatf("%s cyc%0d", name, j), stat, packStat(tExp, 1, 0, 0, 0));
            end else begin
                checkOutput({name, " result"}, stat, packStat(eTap, 0, 1, eLock, eFail));
            end
        end
        if (holdStart) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput({name, " restart"}, stat, packStat(0, 1, 0, 0, 0));
            applyReset();
        end else begin
            @(negedge clk);
            start = 1'b0;
            early = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{"normalLock5", 0, 5,  5,  1'b1, 1'b0, 78};
        vecs[1] = '{"tooLong",     0, 0,  0,  1'b0, 1'b1, 13};
        vecs[2] = '{"tooShort",    0, 16, 15, 1'b0, 1'b1, 208};
        vecs[3] = '{"lockTap1",    0, 1,  1,  1'b1, 1'b0, 26};
        vecs[4] = '{"lockTap15",   0, 15, 15, 1'b1, 1'b0, 208};
        vecs[5] = '{"tie4of8",     1, 4,  2,  1'b1, 1'b0, 39};
        vecs[6] = '{"maj5of8",     1, 5,  3,  1'b1, 1'b0, 52};

        #1 rn = 1'b0;
        #1 checkOutput("powerOnReset", stat, packStat(0, 0, 0, 0, 0));
        #20;
        @(negedge clk);
        rn = 1'b1;
        repeat (5) applyStimulus(1'b0, 1'b1);
        checkOutput("idleNoStart", stat, packStat(0, 0, 0, 0, 0));

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].mode == 0) fillThreshold(vecs[v].param);
            else                   fillVotes(vecs[v].param);
            runCal(vecs[v].name, vecs[v].expTap, vecs[v].expLock, vecs[v].expFail,
                   vecs[v].expEnd, -1, 1'b0);
        end

        for (int r = 0; r < 30; r++) begin
            int  eTap;
            int  eEnd;
            bit  eLock;
            bit  eFail;
            fillRandom($urandom_range(0, NTAPS));
            model(eTap, eLock, eFail, eEnd);
            runCal($sformatf("rand%0d", r), eTap, eLock, eFail, eEnd, -1, 1'b0);
        end

        fillThreshold(5);
        runCal("startWhileBusy", 5, 1'b1, 1'b0, 78, 20, 1'b0);

        fillThreshold(0);
        runCal("holdThroughFin", 0, 1'b0, 1'b1, 13, -1, 1'b1);

        fillThreshold(16);
        applyStimulus(1'b1, seq[0]);
        for (int j = 1; j <= 45; j++) applyStimulus(1'b0, seq[j]);
        checkOutput("midRunTap3", stat, packStat(3, 1, 0, 0, 0));
        #2 rn = 1'b0;
        #1 checkOutput("asyncResetMidRun", stat, packStat(0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rn = 1'b1;
        repeat (20) applyStimulus(1'b0, 1'b1);
        checkOutput("idleAfterReset", stat, packStat(0, 0, 0, 0, 0));

        fillThreshold(2);
        runCal("lockAfterReset", 2, 1'b1, 1'b0, 39, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
